program_sequencer: RTL and testbench

- Instruction issuer that drives the 3-bit Opcode bus of the control unit and supplies the matching data operand to the datapath X-register input.
- Holds a small writable program memory and steps through it with a PC.
- Presents each opcode for exactly one cycle, then waits one execution cycle so the datapath acts on the control unit's registered Tx/Ty/Tz/tula outputs.
- Handles SKIPZ, NOP and HALT internally; these are never forwarded.

---
 rtl/program_sequencer.sv | 142 ++++++++++++++
 tb/tb_program_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Instruction issuer: walks a small writable program memory and drives the control unit's
// Opcode bus plus the datapath operand, resolving SKIPZ/NOP/HALT internally.
module program_sequencer #(
  parameter int         WIDTH   = 8,
  parameter int         AW      = 4,
  parameter logic [2:0] IDLE_OP = 3'b100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [WIDTH+2:0]     prog_wdata,
  input  logic                 status,
  output logic [2:0]           Opcode,
  output logic [WIDTH-1:0]     operand,
  output logic [AW-1:0]        pc,
  output logic                 busy,
  output logic                 done
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [2:0] OP_SKIPZ = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] TWO     = (AW+1)'(2);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_EXEC} state_t;

  logic [WIDTH+2:0] mem_q [DEPTH];

  state_t           state_q;
  logic [2:0]       opcode_q;
  logic [WIDTH-1:0] operand_q;
  logic [AW-1:0]    pc_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH+2:0] fetch_word;
  logic [2:0]       fetch_op;
  logic [WIDTH-1:0] fetch_data;
  logic [AW-1:0]    pc_inc;
  logic [AW:0]      skip_sum;
  logic             pc_last;

  assign fetch_word = mem_q[pc_q];
  assign fetch_op   = fetch_word[WIDTH+2:WIDTH];
  assign fetch_data = fetch_word[WIDTH-1:0];
  assign pc_inc     = pc_q + AW'(1);
  // Carry out of the extended sum means the skip would run past the last address.
  assign skip_sum   = {1'b0, pc_q} + (status ? TWO : ONE);
  assign pc_last    = &pc_q;

  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= IDLE_OP;
      operand_q <= '0;
      pc_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q  <= S_IDLE;
        opcode_q <= IDLE_OP;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              pc_q    <= '0;
              state_q <= S_FETCH;
              busy_q  <= 1'b1;
            end
          end
          S_FETCH: begin
            case (fetch_op)
              OP_SKIPZ: begin
                if (skip_sum[AW]) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  pc_q <= skip_sum[AW-1:0];
                end
              end
              OP_NOP: begin
                if (pc_last) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  pc_q <= pc_inc;
                end
              end
              OP_HALT: begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
              default: begin
                opcode_q  <= fetch_op;
                operand_q <= fetch_data;
                state_q   <= S_ISSUE;
              end
            endcase
          end
          S_ISSUE: begin
            opcode_q <= IDLE_OP;
            state_q  <= S_EXEC;
          end
          S_EXEC: begin
            if (pc_last) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q    <= pc_inc;
              state_q <= S_FETCH;
            end
          end
        endcase
      end
    end
  end

  assign Opcode  = opcode_q;
  assign operand = operand_q;
  assign pc      = pc_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed scenarios plus random programs compared cycle by cycle
// against an instruction-level reference model.
module tb_program_sequencer;
  localparam int         WIDTH   = 8;
  localparam int         AW      = 4;
  localparam int         DEPTH   = 16;
  localparam logic [2:0] IDLE_OP = 3'b100;

  logic             clk = 1'b0;
  logic             rst, start, abort, prog_we, status;
  logic [AW-1:0]    prog_addr;
  logic [WIDTH+2:0] prog_wdata;
  logic [2:0]       Opcode;
  logic [WIDTH-1:0] operand;
  logic [AW-1:0]    pc;
  logic             busy, done;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] opd;
    logic [AW-1:0]    pc;
    logic             busy;
    logic             done;
  } rec_t;

  rec_t             exp_q[$];
  rec_t             obs_q[$];
  logic [WIDTH+2:0] pm [DEPTH];
  logic [WIDTH-1:0] mdl_opd;
  int               checks = 0;
  int               errors = 0;

  program_sequencer #(.WIDTH(WIDTH), .AW(AW), .IDLE_OP(IDLE_OP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .status(status),
    .Opcode(Opcode), .operand(operand), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected per-cycle outputs for one run, walked instruction by instruction.
  function automatic void build_model(input logic st);
    int p, nxt;
    logic [2:0] op;
    logic [WIDTH-1:0] d;
    bit fin;
    exp_q.delete();
    p = 0;
    fin = 0;
    while (!fin) begin
      op = pm[p][WIDTH+2:WIDTH];
      d  = pm[p][WIDTH-1:0];
      exp_q.push_back('{IDLE_OP, mdl_opd, AW'(p), 1'b1, 1'b0});
      if (op <= 3'd4) begin
        mdl_opd = d;
        exp_q.push_back('{op, d, AW'(p), 1'b1, 1'b0});
        exp_q.push_back('{IDLE_OP, d, AW'(p), 1'b1, 1'b0});
        nxt = p + 1;
      end else if (op == 3'd5) begin
        nxt = p + (st ? 2 : 1);
      end else if (op == 3'd6) begin
        nxt = p + 1;
      end else begin
        nxt = DEPTH;
      end
      if (nxt >= DEPTH) fin = 1;
      else p = nxt;
    end
    exp_q.push_back('{IDLE_OP, mdl_opd, AW'(p), 1'b0, 1'b1});
    exp_q.push_back('{IDLE_OP, mdl_opd, AW'(p), 1'b0, 1'b0});
  endfunction

  task automatic write_word(input int addr, input logic [WIDTH+2:0] w);
    prog_we    = 1'b1;
    prog_addr  = AW'(addr);
    prog_wdata = w;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    pm[addr] = w;
  endtask

  task automatic run_capture(input int n);
    obs_q.delete();
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      obs_q.push_back({Opcode, operand, pc, busy, done});
    end
  endtask

  task automatic load_basic();
    write_word(0, {3'b000, 8'h05});
    write_word(1, {3'b001, 8'h03});
    write_word(2, {3'b100, 8'h00});
    write_word(3, {3'b111, 8'h00});
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0; status = 1'b0;
    prog_addr = '0; prog_wdata = '0;
    #12;
    checks++; if (Opcode !== IDLE_OP) begin errors++; $display("FAIL reset_opcode got %b exp %b", Opcode, IDLE_OP); end
    checks++; if (operand !== 8'h00) begin errors++; $display("FAIL reset_operand got %h exp 00", operand); end
    checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    rst = 1'b0;
    mdl_opd = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    load_basic();
    status = 1'b0;
    build_model(1'b0);
    run_capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (obs_q[1].op !== 3'b000 || obs_q[1].opd !== 8'h05) begin errors++; $display("FAIL basic_issue0 got %h exp op 000 opd 05", obs_q[1]); end
    checks++; if (obs_q[4].op !== 3'b001 || obs_q[4].opd !== 8'h03) begin errors++; $display("FAIL basic_issue1 got %h exp op 001 opd 03", obs_q[4]); end
    checks++; if (obs_q[9].done !== 1'b0 || obs_q[10].done !== 1'b1) begin errors++; $display("FAIL basic_done_time got %b%b exp 01", obs_q[9].done, obs_q[10].done); end
  endtask

  task automatic test_skipz();
    bit seen2, issued;
    write_word(0, {3'b000, 8'h11});
    write_word(1, {3'b101, 8'h00});
    write_word(2, {3'b011, 8'h22});
    write_word(3, {3'b111, 8'h00});
    for (int s = 1; s >= 0; s--) begin
      status = s[0];
      build_model(s[0]);
      run_capture(exp_q.size());
      seen2 = 0; issued = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL skipz%0d cyc %0d got %h exp %h", s, i, obs_q[i], exp_q[i]); end
        if (obs_q[i].pc == 4'd2) seen2 = 1;
        if (obs_q[i].op == 3'b011) issued = 1;
      end
      checks++;
      if (issued !== !s[0] || seen2 !== !s[0]) begin
        errors++; $display("FAIL skipz%0d_addr2 got issued=%0d pc2=%0d exp %0d", s, issued, seen2, !s[0]);
      end
    end
  endtask

  task automatic test_nop_fill();
    int fetches;
    for (int a = 0; a < DEPTH; a++) write_word(a, {3'b110, 8'($urandom)});
    build_model(1'b0);
    run_capture(exp_q.size());
    fetches = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL nopfill cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
      if (obs_q[i].busy) fetches++;
    end
    checks++; if (fetches != 16 || obs_q[16].done !== 1'b1 || obs_q[16].pc !== 4'd15) begin
      errors++; $display("FAIL nopfill_end got fetches=%0d done=%b pc=%0d exp 16 1 15", fetches, obs_q[16].done, obs_q[16].pc);
    end
  endtask

  task automatic test_abort();
    load_basic();
    status = 1'b0;
    start = 1'b1;
    repeat (6) begin @(posedge clk); #1; start = 1'b0; end
    checks++; if (busy !== 1'b1 || pc !== 4'd1) begin errors++; $display("FAIL abort_pre got busy=%b pc=%0d exp 1 1", busy, pc); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (pc !== 4'd1 || Opcode !== IDLE_OP) begin errors++; $display("FAIL abort_pc got pc=%0d op=%b exp 1 %b", pc, Opcode, IDLE_OP); end
    checks++; if (operand !== 8'h03) begin errors++; $display("FAIL abort_operand got %h exp 03", operand); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone got %b exp 0", done); end
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start got busy=%b exp 0", busy); end
    mdl_opd = 8'h03;
    build_model(1'b0);
    run_capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_rerun cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (Opcode !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL arst_issue got op=%b busy=%b exp 000 1", Opcode, busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (Opcode !== IDLE_OP || busy !== 1'b0) begin errors++; $display("FAIL arst_ctrl got op=%b busy=%b exp %b 0", Opcode, busy, IDLE_OP); end
    checks++; if (operand !== 8'h00 || pc !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL arst_data got opd=%h pc=%0d done=%b exp 00 0 0", operand, pc, done); end
    rst = 1'b0;
    mdl_opd = '0;
    @(posedge clk); #1;
    build_model(1'b0);
    run_capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL arst_rerun cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_prog_write_busy();
    build_model(1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prog_we = 1'b1; prog_addr = '0; prog_wdata = {3'b010, 8'hAA};
    repeat (4) begin @(posedge clk); #1; end
    prog_we = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pwb_idle got busy=%b exp 0", busy); end
    build_model(1'b0);
    run_capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL pwb_unchanged cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (obs_q[1].op !== 3'b000 || obs_q[1].opd !== 8'h05) begin errors++; $display("FAIL pwb_first got %h exp op 000 opd 05", obs_q[1]); end
    write_word(0, {3'b010, 8'hAA});
    build_model(1'b0);
    run_capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL pwi_rerun cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (obs_q[1].op !== 3'b010 || obs_q[1].opd !== 8'hAA) begin errors++; $display("FAIL pwi_first got %h exp op 010 opd aa", obs_q[1]); end
  endtask

  task automatic test_random();
    logic st;
    for (int it = 0; it < 24; it++) begin
      for (int a = 0; a < DEPTH; a++) write_word(a, {3'($urandom_range(0, 7)), 8'($urandom)});
      st = 1'($urandom_range(0, 1));
      status = st;
      build_model(st);
      run_capture(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random it %0d cyc %0d got %h exp %h", it, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skipz();
    test_nop_fill();
    test_abort();
    test_async_reset();
    test_prog_write_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
